// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time, classifies it for
// illegal, misaligned and out-of-range faults, performs a single-cycle data
// memory access and holds the result until the response is taken.
module load_store_unit #(
  parameter int ADDR_W    = 6,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_offset,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [2:0]        mem_choose,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_wb,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [31:0]       exc_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        load_q;
  logic        store_q;
  logic [31:0] ea;
  logic [2:0]  size;
  logic [32:0] last_byte;
  logic        load_code_ok;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [1:0]  cause;

  // The last byte touched is formed in 33 bits so an address near 2^32 cannot wrap back into range.
  always_comb begin
    ea = req_base + req_offset;
    case (req_funct3[1:0])
      2'b01:   size = 3'd2;
      2'b10:   size = 3'd4;
      default: size = 3'd1;
    endcase
    last_byte    = {1'b0, ea} + {30'd0, size} - 33'd1;
    load_code_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    illegal      = (req_load == req_store) || (req_load && !load_code_ok) ||
                   (req_store && (req_funct3 > 3'b010));
    misaligned   = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    out_of_range = last_byte >= 33'(MEM_BYTES);
    fault        = illegal || misaligned || out_of_range;
    if (illegal)         cause = 2'b00;
    else if (misaligned) cause = req_load ? 2'b01 : 2'b10;
    else                 cause = 2'b11;
  end

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign mem_read   = (state == ACCESS) && load_q;
  assign mem_write  = (state == ACCESS) && store_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      mem_choose <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_data  <= '0;
      resp_rd    <= '0;
      resp_wb    <= 1'b0;
      exc_valid  <= 1'b0;
      exc_cause  <= '0;
      exc_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            load_q     <= req_load;
            store_q    <= req_store;
            mem_choose <= req_funct3;
            mem_addr   <= ea[ADDR_W-1:0];
            mem_wdata  <= req_wdata;
            resp_rd    <= req_rd;
            resp_data  <= '0;
            resp_wb    <= 1'b0;
            exc_valid  <= fault;
            exc_cause  <= fault ? cause : 2'b00;
            exc_addr   <= ea;
            state      <= fault ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          resp_data <= load_q ? mem_rdata : 32'd0;
          resp_wb   <= load_q;
          state     <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a big-endian 64-byte data memory
// that sign/zero-extends reads according to the width code.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_base = 32'd0;
  logic [31:0] req_offset = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [2:0]  mem_choose;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_wb;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];
  logic [5:0] a1, a2, a3;

  load_store_unit #(.ADDR_W(6), .MEM_BYTES(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_choose(mem_choose), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_wb(resp_wb),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  assign a1 = mem_addr + 6'd1;
  assign a2 = mem_addr + 6'd2;
  assign a3 = mem_addr + 6'd3;

  always_comb begin
    case (mem_choose)
      3'b000:  mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
      3'b001:  mem_rdata = {{16{mem[mem_addr][7]}}, mem[mem_addr], mem[a1]};
      3'b010:  mem_rdata = {mem[mem_addr], mem[a1], mem[a2], mem[a3]};
      3'b100:  mem_rdata = {24'd0, mem[mem_addr]};
      3'b101:  mem_rdata = {16'd0, mem[mem_addr], mem[a1]};
      default: mem_rdata = 32'd0;
    endcase
  end

  // Words 0x0D030000 @0, 9 @4 and 25 @8, stored most significant byte first.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h0D; mem[1] <= 8'h03; mem[7] <= 8'h09; mem[11] <= 8'h19;
    end else if (mem_write) begin
      case (mem_choose)
        3'b000: mem[mem_addr] <= mem_wdata[7:0];
        3'b001: begin mem[mem_addr] <= mem_wdata[15:8]; mem[a1] <= mem_wdata[7:0]; end
        default: begin
          mem[mem_addr] <= mem_wdata[31:24]; mem[a1] <= mem_wdata[23:16];
          mem[a2] <= mem_wdata[15:8]; mem[a3] <= mem_wdata[7:0];
        end
      endcase
    end
  end

  // Issues one request and stops once the response is visible; lat counts edges from acceptance.
  task automatic run_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [4:0] rd,
                         output int lat, output int nread, output int nwrite,
                         output logic [5:0] waddr, output logic [2:0] wchoose);
    int cyc;
    nread = 0; nwrite = 0; waddr = '0; wchoose = '0;
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
    cyc = 0;
    while (!req_ready && cyc < 10) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (mem_read) nread++;
      if (mem_write) begin nwrite++; waddr = mem_addr; wchoose = mem_choose; end
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic complete_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL rst_strobes: got %b want 00", {mem_read, mem_write}); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_resp_data: got %h want 0", resp_data); end
    checks++; if (exc_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_exc_valid: got %b want 0", exc_valid); end
    checks++; if (mem_addr !== 6'd0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h want 0", mem_addr); end
    rst = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_load_word();
    int lat, nr, nw; logic [5:0] wa; logic [2:0] wc;
    run_req(1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 32'd0, 5'd7, lat, nr, nw, wa, wc);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL lw4_latency: got %0d want 2", lat); end
    checks++; if (resp_data !== 32'h00000009) begin errors++; $display("[TB] FAIL lw4_data: got %h want 00000009", resp_data); end
    checks++; if (resp_wb !== 1'b1) begin errors++; $display("[TB] FAIL lw4_wb: got %b want 1", resp_wb); end
    checks++; if (resp_rd !== 5'd7) begin errors++; $display("[TB] FAIL lw4_rd: got %0d want 7", resp_rd); end
    checks++; if (exc_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw4_exc: got %b want 0", exc_valid); end
    checks++; if (nr !== 1) begin errors++; $display("[TB] FAIL lw4_read_cycles: got %0d want 1", nr); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL lw4_read_in_resp: got %b want 0", mem_read); end
    complete_resp();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw4_handshake: got %b want 0", resp_valid); end
    // Negative offset: 16 + (-12) = 4.
    run_req(1'b1, 1'b0, 3'b010, 32'd16, 32'hFFFFFFF4, 32'd0, 5'd8, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'h00000009) begin errors++; $display("[TB] FAIL lw_negoff_data: got %h want 00000009", resp_data); end
    checks++; if (exc_addr !== 32'd4) begin errors++; $display("[TB] FAIL lw_negoff_ea: got %h want 00000004", exc_addr); end
    complete_resp();
  endtask

  task automatic test_load_widths();
    int lat, nr, nw; logic [5:0] wa; logic [2:0] wc;
    run_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd1, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'h0000000D) begin errors++; $display("[TB] FAIL lb0_data: got %h want 0000000d", resp_data); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b001, 32'd0, 32'd0, 32'd0, 5'd2, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'h00000D03) begin errors++; $display("[TB] FAIL lh0_data: got %h want 00000d03", resp_data); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b101, 32'd2, 32'd0, 32'd0, 5'd3, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'h00000000) begin errors++; $display("[TB] FAIL lhu2_data: got %h want 00000000", resp_data); end
    checks++; if (exc_valid !== 1'b0) begin errors++; $display("[TB] FAIL lhu2_exc: got %b want 0", exc_valid); end
    complete_resp();
  endtask

  task automatic test_store();
    int lat, nr, nw; logic [5:0] wa; logic [2:0] wc;
    run_req(1'b0, 1'b1, 3'b010, 32'd8, 32'd4, 32'hDEADBEEF, 5'd3, lat, nr, nw, wa, wc);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL sw12_latency: got %0d want 2", lat); end
    checks++; if (nw !== 1) begin errors++; $display("[TB] FAIL sw12_write_cycles: got %0d want 1", nw); end
    checks++; if (nr !== 0) begin errors++; $display("[TB] FAIL sw12_read_cycles: got %0d want 0", nr); end
    checks++; if (wa !== 6'd12) begin errors++; $display("[TB] FAIL sw12_addr: got %0d want 12", wa); end
    checks++; if (wc !== 3'b010) begin errors++; $display("[TB] FAIL sw12_choose: got %b want 010", wc); end
    checks++; if (resp_wb !== 1'b0) begin errors++; $display("[TB] FAIL sw12_wb: got %b want 0", resp_wb); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("[TB] FAIL sw12_data: got %h want 0", resp_data); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL sw12_write_in_resp: got %b want 0", mem_write); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b010, 32'd12, 32'd0, 32'd0, 5'd4, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw12_data: got %h want deadbeef", resp_data); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b000, 32'd12, 32'd0, 32'd0, 5'd5, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'hFFFFFFDE) begin errors++; $display("[TB] FAIL lb12_data: got %h want ffffffde", resp_data); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b100, 32'd12, 32'd0, 32'd0, 5'd6, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'h000000DE) begin errors++; $display("[TB] FAIL lbu12_data: got %h want 000000de", resp_data); end
    complete_resp();
  endtask

  task automatic test_exceptions();
    int lat, nr, nw; logic [5:0] wa; logic [2:0] wc;
    run_req(1'b1, 1'b0, 3'b010, 32'd6, 32'd0, 32'd0, 5'd9, lat, nr, nw, wa, wc);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL lw6_latency: got %0d want 1", lat); end
    checks++; if ({exc_valid, exc_cause} !== 3'b101) begin errors++; $display("[TB] FAIL lw6_cause: got %b want 101", {exc_valid, exc_cause}); end
    checks++; if (exc_addr !== 32'd6) begin errors++; $display("[TB] FAIL lw6_addr: got %h want 00000006", exc_addr); end
    checks++; if (nr !== 0) begin errors++; $display("[TB] FAIL lw6_read_cycles: got %0d want 0", nr); end
    checks++; if ({resp_wb, resp_data} !== 33'd0) begin errors++; $display("[TB] FAIL lw6_wb_data: got %b/%h want 0/0", resp_wb, resp_data); end
    complete_resp();
    run_req(1'b0, 1'b1, 3'b001, 32'd3, 32'd0, 32'h0000FFFF, 5'd9, lat, nr, nw, wa, wc);
    checks++; if ({exc_valid, exc_cause} !== 3'b110) begin errors++; $display("[TB] FAIL sh3_cause: got %b want 110", {exc_valid, exc_cause}); end
    checks++; if (nw !== 0) begin errors++; $display("[TB] FAIL sh3_write_cycles: got %0d want 0", nw); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b011, 32'd0, 32'd0, 32'd0, 5'd9, lat, nr, nw, wa, wc);
    checks++; if ({exc_valid, exc_cause} !== 3'b100) begin errors++; $display("[TB] FAIL ld011_cause: got %b want 100", {exc_valid, exc_cause}); end
    complete_resp();
    // Both op bits set at a misaligned address: the illegal code must outrank misalignment.
    run_req(1'b1, 1'b1, 3'b010, 32'd6, 32'd0, 32'd0, 5'd9, lat, nr, nw, wa, wc);
    checks++; if ({exc_valid, exc_cause} !== 3'b100) begin errors++; $display("[TB] FAIL ldst_cause: got %b want 100", {exc_valid, exc_cause}); end
    checks++; if (nr + nw !== 0) begin errors++; $display("[TB] FAIL ldst_strobes: got %0d want 0", nr + nw); end
    complete_resp();
  endtask

  task automatic test_range();
    int lat, nr, nw; logic [5:0] wa; logic [2:0] wc;
    // 62 is both misaligned for a word and past the end; misalignment outranks range.
    run_req(1'b1, 1'b0, 3'b010, 32'd62, 32'd0, 32'd0, 5'd10, lat, nr, nw, wa, wc);
    checks++; if ({exc_valid, exc_cause} !== 3'b101) begin errors++; $display("[TB] FAIL lw62_cause: got %b want 101", {exc_valid, exc_cause}); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b010, 32'd60, 32'd4, 32'd0, 5'd10, lat, nr, nw, wa, wc);
    checks++; if ({exc_valid, exc_cause} !== 3'b111) begin errors++; $display("[TB] FAIL lw64_cause: got %b want 111", {exc_valid, exc_cause}); end
    checks++; if (exc_addr !== 32'd64) begin errors++; $display("[TB] FAIL lw64_addr: got %h want 00000040", exc_addr); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b010, 32'hFFFFFFFC, 32'd0, 32'd0, 5'd10, lat, nr, nw, wa, wc);
    checks++; if ({exc_valid, exc_cause} !== 3'b111) begin errors++; $display("[TB] FAIL lwtop_cause: got %b want 111", {exc_valid, exc_cause}); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b000, 32'd63, 32'd0, 32'd0, 5'd11, lat, nr, nw, wa, wc);
    checks++; if (exc_valid !== 1'b0) begin errors++; $display("[TB] FAIL lb63_exc: got %b want 0", exc_valid); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL lb63_latency: got %0d want 2", lat); end
    complete_resp();
    run_req(1'b1, 1'b0, 3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd12, lat, nr, nw, wa, wc);
    checks++; if ({exc_valid, exc_addr} !== 33'd0) begin errors++; $display("[TB] FAIL lbwrap_exc_ea: got %b/%h want 0/0", exc_valid, exc_addr); end
    checks++; if (resp_data !== 32'h0000000D) begin errors++; $display("[TB] FAIL lbwrap_data: got %h want 0000000d", resp_data); end
    complete_resp();
  endtask

  task automatic test_back_pressure();
    int lat, nr, nw; logic [5:0] wa; logic [2:0] wc;
    run_req(1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 32'd0, 5'd13, lat, nr, nw, wa, wc);
    // A competing store is presented while the response waits; it must not be taken.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'd0; req_offset = 32'd0; req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({resp_valid, resp_wb, resp_rd} !== 7'b1101101) begin errors++; $display("[TB] FAIL hold_flags: got %b want 1101101", {resp_valid, resp_wb, resp_rd}); end
      checks++; if (resp_data !== 32'h00000009) begin errors++; $display("[TB] FAIL hold_data: got %h want 00000009", resp_data); end
      checks++; if ({req_ready, mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL hold_ready_write: got %b want 00", {req_ready, mem_write}); end
    end
    req_valid = 1'b0; req_store = 1'b0;
    complete_resp();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL hold_release: got %b want 01", {resp_valid, req_ready}); end
    run_req(1'b1, 1'b0, 3'b010, 32'd0, 32'd0, 32'd0, 5'd14, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'h0D030000) begin errors++; $display("[TB] FAIL hold_mem_intact: got %h want 0d030000", resp_data); end
    complete_resp();
  endtask

  task automatic test_reset_mid_flight();
    int lat, nr, nw; logic [5:0] wa; logic [2:0] wc;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'd0; req_offset = 32'd4; req_wdata = 32'h12345678; req_rd = 5'd1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'b0;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("[TB] FAIL rsta_access: got %b want 1", mem_write); end
    rst = 1'b1; #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL rsta_suppress: got %b want 0", mem_write); end
    @(posedge clk); #1;
    checks++; if ({resp_valid, req_ready} !== 2'b00) begin errors++; $display("[TB] FAIL rsta_held: got %b want 00", {resp_valid, req_ready}); end
    rst = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rsta_idle: got %b want 1", req_ready); end
    run_req(1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 32'd0, 5'd2, lat, nr, nw, wa, wc);
    checks++; if (resp_data !== 32'h00000009) begin errors++; $display("[TB] FAIL rsta_old_word: got %h want 00000009", resp_data); end
    // Reset while the response is pending drops it with no handshake.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL rstr_drop: got %b want 01", {resp_valid, req_ready}); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("[TB] FAIL rstr_data: got %h want 0", resp_data); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    test_reset();
    test_load_word();
    test_load_widths();
    test_store();
    test_exceptions();
    test_range();
    test_back_pressure();
    test_reset_mid_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
